// File: rtl/oa222_stim_drv.sv
// oa222_stim_drv: registered stimulus driver and response checker for one OA222 cell.
// Drives the cell inputs from an exhaustive counter or a 6-bit LFSR, holding each vector
// for HOLD cycles. Q is sampled on the last cycle of every hold window, where Q transitions
// and mismatches against (IN1|IN2)&(IN3|IN4)&(IN5|IN6) are counted.
//
// Ports:
//   CLK            clock, all state changes on the rising edge
//   RST            synchronous active-high reset
//   START          begins a run when sampled in IDLE, ignored otherwise
//   MODE           sampled with START: 0 = counter vectors, 1 = LFSR vectors
//   IN1..IN6       registered cell inputs (vector bit0 -> IN1 ... bit5 -> IN6), 0 outside RUN
//   Q_IN           output of the cell under test
//   BUSY           high while a run is in progress
//   DONE           single-cycle pulse on the cycle after the last sample
//   TOGGLES        saturating count of Q transitions between successive samples
//   MISMATCH       saturating count of samples where Q differs from the OA222 equation

module oa222_stim_drv #(
  parameter int unsigned NVEC = 64,       // vectors per run, 1..65535
  parameter int unsigned HOLD = 2,        // cycles per vector, 1..255
  parameter logic [5:0]  SEED = 6'h2B     // LFSR start value, 0 is replaced by 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        MODE,
  output logic        IN1,
  output logic        IN2,
  output logic        IN3,
  output logic        IN4,
  output logic        IN5,
  output logic        IN6,
  input  logic        Q_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] TOGGLES,
  output logic [15:0] MISMATCH
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed starts from 1 instead.
  localparam logic [5:0]  SEED_EFF  = (SEED == 6'h00) ? 6'h01 : SEED;
  localparam logic [15:0] LAST_VEC  = 16'(NVEC - 1);
  localparam logic [7:0]  LAST_HOLD = 8'(HOLD - 1);

  state_t      r_state;
  logic        r_mode;
  logic [5:0]  r_vec;      // vector currently driven on IN1..IN6; zero outside RUN
  logic [15:0] r_vcnt;     // index of the vector being driven
  logic [7:0]  r_hcnt;     // cycles spent on the current vector
  logic        r_prev_q;   // Q at the previous sample point
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_toggles;
  logic [15:0] r_mismatch;

  logic        w_sample;
  logic        w_last;
  logic        w_expected;
  logic [5:0]  w_vec_next;

  // Saturating increment shared by both activity counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Sample on the final cycle of each hold window.
  assign w_sample   = (r_state == S_RUN) && (r_hcnt == LAST_HOLD);
  assign w_last     = (r_vcnt == LAST_VEC);

  // Reference is taken from the registered vector, i.e. exactly what the cell sees.
  assign w_expected = (r_vec[0] | r_vec[1]) & (r_vec[2] | r_vec[3]) & (r_vec[4] | r_vec[5]);

  // Counter mode: r_vec tracks vcnt[5:0], so a 6-bit increment gives the mod-64 wrap.
  // LFSR mode: Fibonacci x^6+x^5+1, period 63.
  assign w_vec_next = r_mode ? {r_vec[4:0], r_vec[5] ^ r_vec[4]} : r_vec + 6'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_vec      <= 6'h00;
      r_vcnt     <= 16'd0;
      r_hcnt     <= 8'd0;
      r_prev_q   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_toggles  <= 16'd0;
      r_mismatch <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_mode     <= MODE;
            r_vec      <= MODE ? SEED_EFF : 6'h00;
            r_vcnt     <= 16'd0;
            r_hcnt     <= 8'd0;
            r_prev_q   <= 1'b0;
            r_toggles  <= 16'd0;
            r_mismatch <= 16'd0;
          end
        end

        S_RUN: begin
          if (w_sample) begin
            if (Q_IN != w_expected) begin
              r_mismatch <= sat_inc(r_mismatch);
            end
            if (Q_IN != r_prev_q) begin
              r_toggles <= sat_inc(r_toggles);
            end
            r_prev_q <= Q_IN;
            r_hcnt   <= 8'd0;
            if (w_last) begin
              // Inputs return to zero together with the DONE pulse.
              r_state <= S_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_vec   <= 6'h00;
            end else begin
              r_vcnt <= r_vcnt + 16'd1;
              r_vec  <= w_vec_next;
            end
          end else begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end

        S_FIN: begin
          // START here is dropped, not remembered for the IDLE cycle.
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_vec   <= 6'h00;
        end
      endcase
    end
  end

  assign IN1      = r_vec[0];
  assign IN2      = r_vec[1];
  assign IN3      = r_vec[2];
  assign IN4      = r_vec[3];
  assign IN5      = r_vec[4];
  assign IN6      = r_vec[5];
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign TOGGLES  = r_toggles;
  assign MISMATCH = r_mismatch;

endmodule

// File: tb/tb_oa222_stim_drv.sv
// Bench for oa222_stim_drv: four parameterisations share clock, reset and MODE,
// each has its own START and its own cell model on Q_IN.
module tb_oa222_stim_drv;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             RST;
  logic             MODE;
  logic [3:0]       st;
  logic [3:0][5:0]  vin;
  logic [3:0]       busy, done, q_in;
  logic [3:0][15:0] tog, mis;

  // Cell model selection per unit: 0 ideal, 1 tied 0, 2 inverted, 3 ideal xor per-vector flip
  int         qm [4];
  logic [3:0] flip;

  int unsigned nv [4] = '{64, 63, 70, 1};
  int unsigned hd [4] = '{2, 2, 3, 1};
  logic [5:0]  sd [4] = '{6'h2B, 6'h2B, 6'h00, 6'h2B};

  logic [5:0] ev   [0:127];
  logic       fl   [0:127];
  logic [5:0] seen [0:127];

  int total = 0;
  int bad   = 0;

  function automatic logic oa(input logic [5:0] v);
    return (v[0] | v[1]) & (v[2] | v[3]) & (v[4] | v[5]);
  endfunction

  always_comb begin
    q_in = '0;
    for (int i = 0; i < 4; i++) begin
      case (qm[i])
        0:       q_in[i] = oa(vin[i]);
        1:       q_in[i] = 1'b0;
        2:       q_in[i] = ~oa(vin[i]);
        default: q_in[i] = oa(vin[i]) ^ flip[i];
      endcase
    end
  end

  oa222_stim_drv #(.NVEC(64), .HOLD(2), .SEED(6'h2B)) u0 (
    .CLK(CLK), .RST(RST), .START(st[0]), .MODE(MODE),
    .IN1(vin[0][0]), .IN2(vin[0][1]), .IN3(vin[0][2]), .IN4(vin[0][3]), .IN5(vin[0][4]), .IN6(vin[0][5]),
    .Q_IN(q_in[0]), .BUSY(busy[0]), .DONE(done[0]), .TOGGLES(tog[0]), .MISMATCH(mis[0]));

  oa222_stim_drv #(.NVEC(63), .HOLD(2), .SEED(6'h2B)) u1 (
    .CLK(CLK), .RST(RST), .START(st[1]), .MODE(MODE),
    .IN1(vin[1][0]), .IN2(vin[1][1]), .IN3(vin[1][2]), .IN4(vin[1][3]), .IN5(vin[1][4]), .IN6(vin[1][5]),
    .Q_IN(q_in[1]), .BUSY(busy[1]), .DONE(done[1]), .TOGGLES(tog[1]), .MISMATCH(mis[1]));

  oa222_stim_drv #(.NVEC(70), .HOLD(3), .SEED(6'h00)) u2 (
    .CLK(CLK), .RST(RST), .START(st[2]), .MODE(MODE),
    .IN1(vin[2][0]), .IN2(vin[2][1]), .IN3(vin[2][2]), .IN4(vin[2][3]), .IN5(vin[2][4]), .IN6(vin[2][5]),
    .Q_IN(q_in[2]), .BUSY(busy[2]), .DONE(done[2]), .TOGGLES(tog[2]), .MISMATCH(mis[2]));

  oa222_stim_drv #(.NVEC(1), .HOLD(1), .SEED(6'h2B)) u3 (
    .CLK(CLK), .RST(RST), .START(st[3]), .MODE(MODE),
    .IN1(vin[3][0]), .IN2(vin[3][1]), .IN3(vin[3][2]), .IN4(vin[3][3]), .IN5(vin[3][4]), .IN6(vin[3][5]),
    .Q_IN(q_in[3]), .BUSY(busy[3]), .DONE(done[3]), .TOGGLES(tog[3]), .MISMATCH(mis[3]));

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // One complete run on unit u. The expected vector list and Q sequence are built
  // from the vector rules first, then the DUT is observed cycle by cycle.
  // pa/pb: cycles (1 = first RUN cycle) during which START is pulsed again.
  task automatic do_run(input int u, input logic md, input int qmode,
                        input int pa, input int pb, output int atog, output int amis);
    int n, h, err, bcnt, dcnt, dcyc, etog, emis, k;
    logic [5:0] v;
    logic qv, pq;
    n = int'(nv[u]);
    h = int'(hd[u]);
    v = md ? ((sd[u] == 6'h00) ? 6'h01 : sd[u]) : 6'h00;
    etog = 0; emis = 0; pq = 1'b0;
    for (int i = 0; i < n; i++) begin
      ev[i] = md ? v : 6'(i % 64);
      fl[i] = (qmode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      case (qmode)
        0:       qv = oa(ev[i]);
        1:       qv = 1'b0;
        2:       qv = ~oa(ev[i]);
        default: qv = oa(ev[i]) ^ fl[i];
      endcase
      if (qv != oa(ev[i])) emis++;
      if (qv != pq) etog++;
      pq = qv;
      v = {v[4:0], v[5] ^ v[4]};
    end

    qm[u] = qmode; flip[u] = 1'b0; MODE = md; st[u] = 1'b1;
    @(posedge CLK); #1;
    st[u] = 1'b0;
    MODE = ~md;   // must already be latched
    err = 0; bcnt = 0; dcnt = 0; dcyc = 0;
    for (int c = 1; c <= n * h + 4; c++) begin
      if (c <= n * h) begin
        k = (c - 1) / h;
        flip[u] = fl[k];
        if (busy[u]) bcnt++;
        if (vin[u] != ev[k]) err++;
        if ((c - 1) % h == 0) seen[k] = vin[u];
      end else begin
        flip[u] = 1'b0;
        if (vin[u] != 6'h00 || busy[u]) err++;
      end
      if (done[u]) begin dcnt++; dcyc = c; end
      st[u] = (c == pa || c == pb);
      @(posedge CLK); #1;
    end
    st[u] = 1'b0;
    check("busy_cycles", bcnt, n * h);
    check("done_count", dcnt, 1);
    check("done_cycle", dcyc, n * h + 1);
    check("vector_sequence_errors", err, 0);
    check("toggles_vs_model", int'(tog[u]), etog);
    check("mis_vs_model", int'(mis[u]), emis);
    atog = int'(tog[u]);
    amis = int'(mis[u]);
  endtask

  typedef struct {
    int   u;
    logic md;
    int   qmode;
    int   etog;   // -1: model only
    int   emis;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int atog, amis, cnt, dcnt;
    logic [63:0] hit;

    tbl[0] = '{0, 1'b0, 0, 17, 0};
    tbl[1] = '{0, 1'b0, 1, 0, 27};
    tbl[2] = '{0, 1'b0, 2, 18, 64};
    tbl[3] = '{1, 1'b1, 0, -1, 0};
    tbl[4] = '{2, 1'b1, 0, -1, 0};
    tbl[5] = '{2, 1'b0, 0, -1, 0};
    tbl[6] = '{3, 1'b0, 0, 0, 0};
    tbl[7] = '{3, 1'b1, 0, 1, 0};

    RST = 1'b1; MODE = 1'b0; st = '0; flip = '0;
    for (int i = 0; i < 4; i++) qm[i] = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_in", int'(vin[0]), 0);
    check("reset_toggles", int'(tog[0]), 0);
    check("reset_mis", int'(mis[0]), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Table-driven runs
    for (int i = 0; i < 8; i++) begin
      do_run(tbl[i].u, tbl[i].md, tbl[i].qmode, 0, 0, atog, amis);
      if (tbl[i].etog >= 0) check($sformatf("tbl%0d_toggles", i), atog, tbl[i].etog);
      check($sformatf("tbl%0d_mis", i), amis, tbl[i].emis);
    end

    // LFSR run covers every nonzero vector once, starting at the seed
    do_run(1, 1'b1, 0, 0, 0, atog, amis);
    hit = '0;
    cnt = 0;
    for (int i = 0; i < 63; i++) begin
      if (seen[i] != 6'h00 && !hit[seen[i]]) cnt++;
      hit[seen[i]] = 1'b1;
    end
    check("lfsr_distinct_nonzero", cnt, 63);
    check("lfsr_first_vec", int'(seen[0]), 'h2B);

    // Zero seed starts at 1
    do_run(2, 1'b1, 0, 0, 0, atog, amis);
    check("zero_seed_first_vec", int'(seen[0]), 1);

    // START during RUN and on the FIN cycle is ignored
    do_run(0, 1'b0, 0, 37, 129, atog, amis);
    check("ignored_start_toggles", atog, 17);
    check("ignored_start_mis", amis, 0);

    // Reset at cycle 40 of a counter run with an inverted cell
    qm[0] = 2; MODE = 1'b0; st[0] = 1'b1;
    @(posedge CLK); #1;
    st[0] = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= 46; c++) begin
      if (c == 40) begin
        check("pre_reset_mis", int'(mis[0]), 19);
        RST = 1'b1;
      end
      if (c == 41) begin
        RST = 1'b0;
        check("post_reset_busy", int'(busy[0]), 0);
        check("post_reset_in", int'(vin[0]), 0);
        check("post_reset_toggles", int'(tog[0]), 0);
        check("post_reset_mis", int'(mis[0]), 0);
      end
      if (c >= 41 && done[0]) dcnt++;
      @(posedge CLK); #1;
    end
    check("post_reset_no_done", dcnt, 0);
    do_run(0, 1'b0, 0, 0, 0, atog, amis);
    check("after_reset_toggles", atog, 17);
    check("after_reset_mis", amis, 0);

    // Randomized runs with a per-vector faulty cell
    for (int r = 0; r < 8; r++) begin
      int u, pa;
      logic md;
      u  = $urandom_range(0, 2);
      md = 1'($urandom_range(0, 1));
      pa = (r % 2 == 0) ? $urandom_range(2, int'(nv[u] * hd[u])) : 0;
      do_run(u, md, 3, pa, 0, atog, amis);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
